// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The master drives operands and out_ready; the slave drives the result.
interface logic_unit_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit: bitwise, logical and accumulating AND ops
// behind a valid/ready handshake, with a global enable that freezes everything.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  logic_unit_if.slave lu
);

  localparam logic [2:0] OpAnd    = 3'b000;
  localparam logic [2:0] OpOr     = 3'b001;
  localparam logic [2:0] OpXor    = 3'b010;
  localparam logic [2:0] OpNand   = 3'b011;
  localparam logic [2:0] OpLand   = 3'b100;
  localparam logic [2:0] OpLor    = 3'b101;
  localparam logic [2:0] OpAccAnd = 3'b110;
  localparam logic [2:0] OpAccClr = 3'b111;

  logic             s1_v_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [2:0]       s1_op_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_zero_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] result;
  logic             advance;
  logic             accept;

  assign advance = enable && (!out_valid_q || lu.out_ready);
  assign accept  = lu.in_valid && lu.in_ready;

  assign lu.in_ready  = enable && (!s1_v_q || advance);
  assign lu.out_valid = out_valid_q;
  assign lu.out_data  = out_data_q;
  assign lu.out_zero  = out_zero_q;

  // acc_d only differs from acc_q for the two accumulator opcodes.
  always_comb begin
    result = '0;
    acc_d  = acc_q;
    unique case (s1_op_q)
      OpAnd:    result = s1_a_q & s1_b_q;
      OpOr:     result = s1_a_q | s1_b_q;
      OpXor:    result = s1_a_q ^ s1_b_q;
      OpNand:   result = ~(s1_a_q & s1_b_q);
      OpLand:   result[0] = (|s1_a_q) && (|s1_b_q);
      OpLor:    result[0] = (|s1_a_q) || (|s1_b_q);
      OpAccAnd: begin
        acc_d  = acc_q & s1_a_q;
        result = acc_d;
      end
      OpAccClr: begin
        acc_d  = '1;
        result = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_op_q <= '0;
    end else if (accept) begin
      s1_v_q  <= 1'b1;
      s1_a_q  <= lu.A;
      s1_b_q  <= lu.B;
      s1_op_q <= lu.op;
    end else if (advance) begin
      s1_v_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b1;
      acc_q       <= '1;
    end else if (advance) begin
      out_valid_q <= s1_v_q;
      if (s1_v_q) begin
        out_data_q <= result;
        out_zero_q <= (result == '0);
        acc_q      <= acc_d;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: a driver feeds queued transactions,
// a reference model predicts results at accept time, a monitor checks outputs.
module tb_logic_unit_pipe;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic en1;

  always #5 clk = ~clk;

  logic_unit_if #(.WIDTH(W)) lu ();
  logic_unit_if #(.WIDTH(1)) lu1 ();

  logic_unit_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .enable(enable), .lu(lu));
  logic_unit_pipe #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .enable(en1), .lu(lu1));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
  } txn_t;

  typedef struct {
    logic [W-1:0] data;
    logic         zero;
    int           cyc;
  } exp_t;

  txn_t         pending[$];
  exp_t         sb[$];
  int           passed = 0;
  int           total = 0;
  int           cyc = 0;
  int           accepted = 0;
  int           produced = 0;
  int           valid_pct = 100;
  int           rdy_pct = 100;
  bit           lat_check = 1'b0;
  logic [W-1:0] acc_m = '1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: results straight from the opcode definitions.
  function automatic logic [W-1:0] model(input txn_t t);
    case (t.op)
      3'd0: return t.a & t.b;
      3'd1: return t.a | t.b;
      3'd2: return t.a ^ t.b;
      3'd3: return ~(t.a & t.b);
      3'd4: return (t.a != 0 && t.b != 0) ? W'(1) : W'(0);
      3'd5: return (t.a != 0 || t.b != 0) ? W'(1) : W'(0);
      3'd6: begin
        acc_m = acc_m & t.a;
        return acc_m;
      end
      default: begin
        acc_m = '1;
        return '1;
      end
    endcase
  endfunction

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    txn_t t;
    t.a = a;
    t.b = b;
    t.op = op;
    pending.push_back(t);
  endtask

  // Driver: presents the next pending transaction, holds it until accepted.
  initial begin
    txn_t t;
    exp_t e;
    bit   took;
    took = 1'b0;
    lu.in_valid = 1'b0;
    lu.A = '0;
    lu.B = '0;
    lu.op = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!lu.in_valid || took) begin
        took = 1'b0;
        if (pending.size() > 0 && !rst && $urandom_range(99) < valid_pct) begin
          t = pending.pop_front();
          lu.A = t.a;
          lu.B = t.b;
          lu.op = t.op;
          lu.in_valid = 1'b1;
        end else begin
          lu.in_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (!rst && lu.in_valid && lu.in_ready) begin
        e.data = model(t);
        e.zero = (e.data == 0);
        e.cyc = cyc;
        sb.push_back(e);
        accepted++;
        took = 1'b1;
      end
    end
  end

  initial begin
    lu.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      lu.out_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  // Monitor: every consumed output is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && enable && lu.out_valid && lu.out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_output", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_data", 32'(lu.out_data), 32'(e.data));
        check("out_zero", 32'(lu.out_zero), 32'(e.zero));
        if (lat_check) check("latency", 32'(cyc - e.cyc), 32'd2);
      end
      produced++;
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() > 0 || pending.size() > 0 || lu.in_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < budget), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int pbase;
    logic exp1;
    logic acc1;
    rst = 1'b1;
    enable = 1'b1;
    en1 = 1'b1;
    lu1.in_valid = 1'b0;
    lu1.A = '0;
    lu1.B = '0;
    lu1.op = '0;
    lu1.out_ready = 1'b1;
    #2;
    check("rst_out_valid", 32'(lu.out_valid), 32'd0);
    check("rst_out_data", 32'(lu.out_data), 32'd0);
    check("rst_out_zero", 32'(lu.out_zero), 32'd1);
    check("rst_in_ready", 32'(lu.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Bitwise ops, logical ops and accumulator chain with full-rate timing.
    lat_check = 1'b1;
    for (int i = 0; i < 4; i++) push(4'b1100, 4'b1010, 3'(i));
    push(4'b0100, 4'b0000, 3'd4);
    push(4'b0100, 4'b0000, 3'd5);
    push(4'b0000, 4'b0000, 3'd7);
    push(4'b1101, 4'b0000, 3'd6);
    push(4'b0111, 4'b1111, 3'd6);
    push(4'b0010, 4'b0101, 3'd6);
    wait_drain(100);
    lat_check = 1'b0;

    // Backpressure: only two accepts, then the output holds.
    rdy_pct = 0;
    base = accepted;
    pbase = produced;
    push(4'b1111, 4'b0011, 3'd0);
    push(4'b1000, 4'b0001, 3'd1);
    push(4'b1010, 4'b0110, 3'd2);
    push(4'b0101, 4'b0101, 3'd3);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("bp_accepts", 32'(accepted - base), 32'd2);
    check("bp_in_ready", 32'(lu.in_ready), 32'd0);
    check("bp_out_valid", 32'(lu.out_valid), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_data", 32'(lu.out_data), 32'(sb[0].data));
    end
    rdy_pct = 100;
    wait_drain(100);
    check("bp_all_out", 32'(produced - pbase), 32'd4);

    // Enable low with S1 and S2 occupied by accumulator work.
    rdy_pct = 0;
    push(4'b0000, 4'b0000, 3'd7);
    push(4'b1011, 4'b0000, 3'd6);
    push(4'b0110, 4'b1001, 3'd6);
    repeat (5) @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("en_in_ready", 32'(lu.in_ready), 32'd0);
      check("en_out_valid", 32'(lu.out_valid), 32'd1);
      check("en_out_data", 32'(lu.out_data), 32'(sb[0].data));
      @(posedge clk);
    end
    #1 enable = 1'b1;
    rdy_pct = 100;
    wait_drain(100);

    // Reset after an ACC_AND has reached S2.
    rdy_pct = 0;
    base = accepted;
    push(4'b0000, 4'b0000, 3'd7);
    push(4'b0011, 4'b0000, 3'd6);
    push(4'b0001, 4'b0001, 3'd1);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(lu.out_valid), 32'd0);
    check("mid_rst_out_data", 32'(lu.out_data), 32'd0);
    sb.delete();
    acc_m = '1;
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_out_valid", 32'(lu.out_valid), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_pct = 100;
    push(4'b1010, 4'(($urandom_range(15))), 3'd6);
    wait_drain(100);

    // Randomized traffic with random gaps, backpressure and enable stalls.
    base = accepted;
    pbase = produced;
    valid_pct = 70;
    rdy_pct = 60;
    for (int i = 0; i < 300; i++) begin
      push(($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15)),
           ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15)),
           3'($urandom_range(7)));
    end
    for (int n = 0; n < 5000 && pending.size() > 0; n++) begin
      @(posedge clk);
      #1 enable = ($urandom_range(9) != 0);
    end
    @(posedge clk);
    #1 enable = 1'b1;
    valid_pct = 100;
    rdy_pct = 100;
    wait_drain(200);
    check("rand_no_loss", 32'(produced - pbase), 32'(accepted - base));
    check("rand_count", 32'(accepted - base), 32'd300);

    // WIDTH=1 instance: every opcode against every operand pair.
    acc1 = 1'b1;
    for (int o = 0; o < 8; o++) begin
      for (int ab = 0; ab < 4; ab++) begin
        @(posedge clk);
        #1;
        lu1.A = ab[1];
        lu1.B = ab[0];
        lu1.op = 3'(o);
        lu1.in_valid = 1'b1;
        case (o)
          0: exp1 = ab[1] & ab[0];
          1: exp1 = ab[1] | ab[0];
          2: exp1 = ab[1] ^ ab[0];
          3: exp1 = ~(ab[1] & ab[0]);
          4: exp1 = (ab[1] != 0) && (ab[0] != 0);
          5: exp1 = (ab[1] != 0) || (ab[0] != 0);
          6: begin
            acc1 = acc1 & ab[1];
            exp1 = acc1;
          end
          default: begin
            acc1 = 1'b1;
            exp1 = 1'b1;
          end
        endcase
        @(posedge clk);
        #1 lu1.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w1_out_valid", 32'(lu1.out_valid), 32'd1);
        check("w1_out_data", 32'(lu1.out_data), 32'(exp1));
        check("w1_out_zero", 32'(lu1.out_zero), 32'(!exp1));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined successor to the ALU's single-bit logical-AND unit. It accepts two WIDTH-bit operands and a 3-bit opcode through a valid/ready handshake, and returns a registered WIDTH-bit result plus a zero flag two cycles later. It supports bitwise, logical and accumulating AND operations. It sits between the ALU operand mux and the result writeback; the global `enable` stalls it without losing data.

## Interface
- `WIDTH`, default 4: operand and result width; legal values are ≥1.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `enable` input, 1 bit: when low, the pipeline freezes (no accept, no advance).
- `in_valid` input, 1 bit: operands and opcode are valid.
- `in_ready` output, 1 bit: the block can accept this cycle.
- `A` input, WIDTH bits: operand A.
- `B` input, WIDTH bits: operand B.
- `op` input, 3 bits: opcode.
- `out_valid` output, 1 bit: `out_data` and `out_zero` are valid.
- `out_ready` input, 1 bit: the consumer accepts this cycle.
- `out_data` output, WIDTH bits: registered result.
- `out_zero` output, 1 bit: registered flag, 1 when `out_data` is all zeros.

## Operation
- Opcodes:
  - 000 AND: A&B
  - 001 OR: A|B
  - 010 XOR: A^B
  - 011 NAND: ~(A&B)
  - 100 LAND: (|A && |B) zero-extended to WIDTH
  - 101 LOR: (|A || |B) zero-extended to WIDTH
  - 110 ACC_AND: acc <= acc & A; the result is the new acc
  - 111 ACC_CLR: acc <= all ones; the result is all ones
- Internal WIDTH-bit accumulator `acc`. It changes only when an ACC_AND or ACC_CLR transaction moves from stage 1 to stage 2. Under ACC_AND, B is ignored.
- Stage 1 (S1): registers A, B and op, plus its valid bit `s1_v`.
- Stage 2 (S2): computes the result from the S1 contents and registers it into `out_data`, `out_zero` and `out_valid`.
- `advance` = enable && (!out_valid || out_ready).
- `in_ready` = enable && (!s1_v || advance). This is combinational from `out_ready` and `enable`.
- Input accept: in_valid && in_ready.
  - S1 loads A, B and op, and sets `s1_v` = 1.
  - Otherwise, if `advance` is high, `s1_v` is cleared.
- S2 update when `advance` is high:
  - out_valid <= s1_v.
  - If `s1_v` = 1, `out_data` and `out_zero` load the new result.
  - If `s1_v` = 0, `out_data` and `out_zero` hold their previous values.
- When `enable` is low, every register holds and `in_ready` = 0. `out_valid` keeps its value; a pending output stays presented but is not consumed. The consumer must not treat `out_ready` as taking effect while `enable` is low.
- Transactions complete in acceptance order. No transaction is dropped or duplicated under any `in_valid`/`out_ready` pattern.

## Timing
- Reset values (asynchronous, immediate on `rst`):
  - `s1_v` = 0, `out_valid` = 0, `out_data` = 0, `out_zero` = 1, `acc` = all ones.
  - `in_ready` = `enable` (combinational).
- Latency: an input accepted at edge k produces `out_valid` = 1 after edge k+1, provided `advance` is high at k+1.
- Throughput: one transaction per cycle while `enable` = 1 and `out_ready` = 1.
- Backpressure: while `out_valid` = 1 and `out_ready` = 0, `out_data`, `out_zero` and `out_valid` hold stable. At most one further transaction is accepted, into S1; after that, `in_ready` = 0.
- Simultaneous output consume and input accept in the same cycle: the S1 contents move to S2 and the new input loads S1.
- Back-to-back ACC ops: each sees the `acc` value produced by the immediately preceding ACC op. No hazard exists because `acc` updates at S2 load.
- Reset mid-operation: all in-flight transactions are discarded, no output fires, and `acc` returns to all ones.
- WIDTH=1: LAND equals AND and LOR equals OR. Both are still required to be correct.

## Test plan
- Reset, then with WIDTH=4, enable=1 and out_ready=1, send A=4'b1100, B=4'b1010 with op=000, then 001, then 010, then 011 on consecutive cycles. Required: results 1000, 1110, 0110, 0111 on consecutive cycles, each 2 cycles after its accept, with out_zero=0.
- LAND with A=4'b0100, B=4'b0000 → out_data=0000, out_zero=1. LOR with the same operands → 0001, out_zero=0.
- Send ACC_CLR, then ACC_AND A=1101, then ACC_AND A=0111, then ACC_AND A=0010. Required: results 1111, 1101, 0101, 0000; the last has out_zero=1.
- Backpressure: hold out_ready=0 while streaming 4 transactions. Required: in_ready drops after 2 accepts and out_data stays stable. Then release out_ready. Required: all 4 results emerge in order, with no duplicate or loss.
- Drive enable=0 for 3 cycles while data is in S1 and S2. Required: in_ready=0, and out_valid, out_data and acc unchanged. On re-enable, the stream resumes in order.
- Assert rst mid-stream, after an ACC_AND has reached S2. Required: out_valid=0 and out_data=0 immediately. A subsequent ACC_AND A=1010 yields 1010, because acc was reset to all ones.
